// File: rtl/lda_ovo_seq_if.sv
// Interface bundling the feature input, result output and config write
// port of the sequential one-vs-one LDA classifier.
interface lda_ovo_seq_if #(
    parameter int unsigned DIMS    = 6,
    parameter int unsigned CLASSES = 3,
    parameter int unsigned DW      = 8,
    parameter int unsigned WW      = 8
);
    localparam int unsigned P    = CLASSES * (CLASSES - 1) / 2;
    localparam int unsigned ACCW = DW + WW + $clog2(DIMS);
    localparam int unsigned AW   = $clog2(P * DIMS + P);
    localparam int unsigned CIW  = $clog2(CLASSES);

    // Feature vector handshake
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic [DIMS-1:0][DW-1:0]  din_i;

    // Result handshake
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [CLASSES-1:0]       class_onehot_o;
    logic [CIW-1:0]           class_idx_o;

    // Config write port
    logic                     cfg_we_i;
    logic [AW-1:0]            cfg_addr_i;
    logic [ACCW-1:0]          cfg_data_i;
    logic                     cfg_ready_o;

    modport slave (
        input  in_valid_i, din_i, out_ready_i, cfg_we_i, cfg_addr_i, cfg_data_i,
        output in_ready_o, out_valid_o, class_onehot_o, class_idx_o, cfg_ready_o
    );

    modport master (
        output in_valid_i, din_i, out_ready_i, cfg_we_i, cfg_addr_i, cfg_data_i,
        input  in_ready_o, out_valid_o, class_onehot_o, class_idx_o, cfg_ready_o
    );
endinterface

// File: rtl/lda_ovo_seq.sv
// Time-multiplexed one-vs-one LDA classifier: one signed MAC walks every
// pairwise discriminant, each pair casts a vote, and the majority class wins.
module lda_ovo_seq #(
    parameter int unsigned DIMS    = 6,
    parameter int unsigned CLASSES = 3,
    parameter int unsigned DW      = 8,
    parameter int unsigned WW      = 8
) (
    input logic        clk_i,
    input logic        rstn_i,
    lda_ovo_seq_if.slave bus
);
    localparam int unsigned P     = CLASSES * (CLASSES - 1) / 2;
    localparam int unsigned ACCW  = DW + WW + $clog2(DIMS);
    localparam int unsigned AW    = $clog2(P * DIMS + P);
    localparam int unsigned CIW   = $clog2(CLASSES);
    localparam int unsigned IW    = (DIMS > 1) ? $clog2(DIMS) : 1;
    localparam int unsigned PW    = (P > 1) ? $clog2(P) : 1;
    // A class can collect at most CLASSES-1 votes, which always fits in CIW bits
    localparam int unsigned VW    = CIW;
    localparam int unsigned PRODW = DW + WW;

    typedef enum logic [1:0] {StIdle, StMac, StVote, StHold} state_e;

    state_e state_q, state_d;

    // Config register file
    logic signed [WW-1:0]   w_q [P][DIMS];
    logic signed [ACCW-1:0] c_q [P];

    // Datapath state
    logic [DIMS-1:0][DW-1:0] din_q;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [PW-1:0]           pair_q, pair_d;
    logic [CIW-1:0]          cls_a_q, cls_a_d;
    logic [CIW-1:0]          cls_b_q, cls_b_d;
    logic [VW-1:0]           votes_q [CLASSES];
    logic [VW-1:0]           votes_d [CLASSES];
    logic [CLASSES-1:0]      onehot_q, onehot_d;
    logic [CIW-1:0]          cidx_q, cidx_d;
    logic                    out_valid_q, out_valid_d;
    logic                    din_load;

    // MAC datapath
    logic signed [PRODW-1:0] din_ext, w_ext, prod;
    logic signed [ACCW-1:0]  prod_ext, score;
    logic                    last_dim, last_pair, pair_wins_b;

    // Argmax over votes
    logic [CIW-1:0]          best_idx;
    logic [VW-1:0]           best_val;

    logic                    cfg_en;

    assign cfg_en = bus.cfg_we_i && (state_q == StIdle);

    // Register file write; only honoured while idle
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int p = 0; p < P; p++) begin
                for (int i = 0; i < DIMS; i++) begin
                    w_q[p][i] <= '0;
                end
                c_q[p] <= '0;
            end
        end else if (cfg_en) begin
            for (int p = 0; p < P; p++) begin
                for (int i = 0; i < DIMS; i++) begin
                    if (bus.cfg_addr_i == AW'(p * DIMS + i)) begin
                        w_q[p][i] <= bus.cfg_data_i[WW-1:0];
                    end
                end
                if (bus.cfg_addr_i == AW'(P * DIMS + p)) begin
                    c_q[p] <= bus.cfg_data_i;
                end
            end
        end
    end

    // Signed product of the current feature and weight, widened to the accumulator
    always_comb begin
        din_ext     = PRODW'($signed(din_q[idx_q]));
        w_ext       = PRODW'(w_q[pair_q][idx_q]);
        prod        = din_ext * w_ext;
        prod_ext    = ACCW'(prod);
        score       = acc_q + prod_ext;
        last_dim    = (idx_q == IW'(DIMS - 1));
        last_pair   = (pair_q == PW'(P - 1));
        pair_wins_b = (score > c_q[pair_q]);
    end

    // Majority vote; strict compare keeps ties on the lowest class index
    always_comb begin
        best_idx = '0;
        best_val = votes_q[0];
        for (int c = 1; c < CLASSES; c++) begin
            if (votes_q[c] > best_val) begin
                best_idx = CIW'(c);
                best_val = votes_q[c];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        pair_d      = pair_q;
        cls_a_d     = cls_a_q;
        cls_b_d     = cls_b_q;
        votes_d     = votes_q;
        onehot_d    = onehot_q;
        cidx_d      = cidx_q;
        out_valid_d = out_valid_q;
        din_load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid_i) begin
                    din_load = 1'b1;
                    acc_d    = '0;
                    idx_d    = '0;
                    pair_d   = '0;
                    cls_a_d  = '0;
                    cls_b_d  = CIW'(1);
                    for (int c = 0; c < CLASSES; c++) begin
                        votes_d[c] = '0;
                    end
                    state_d = StMac;
                end
            end
            StMac: begin
                if (last_dim) begin
                    if (pair_wins_b) begin
                        votes_d[cls_b_q] = votes_q[cls_b_q] + VW'(1);
                    end else begin
                        votes_d[cls_a_q] = votes_q[cls_a_q] + VW'(1);
                    end
                    acc_d = '0;
                    idx_d = '0;
                    if (last_pair) begin
                        state_d = StVote;
                    end else begin
                        pair_d = pair_q + PW'(1);
                        // Walk (a,b) lexicographically with a<b
                        if (cls_b_q == CIW'(CLASSES - 1)) begin
                            cls_a_d = cls_a_q + CIW'(1);
                            cls_b_d = cls_a_q + CIW'(2);
                        end else begin
                            cls_b_d = cls_b_q + CIW'(1);
                        end
                    end
                end else begin
                    acc_d = score;
                    idx_d = idx_q + IW'(1);
                end
            end
            StVote: begin
                onehot_d           = '0;
                onehot_d[best_idx] = 1'b1;
                cidx_d             = best_idx;
                out_valid_d        = 1'b1;
                state_d            = StHold;
            end
            StHold: begin
                if (bus.out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            din_q       <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            pair_q      <= '0;
            cls_a_q     <= '0;
            cls_b_q     <= '0;
            onehot_q    <= '0;
            cidx_q      <= '0;
            out_valid_q <= 1'b0;
            for (int c = 0; c < CLASSES; c++) begin
                votes_q[c] <= '0;
            end
        end else begin
            if (din_load) begin
                din_q <= bus.din_i;
            end
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            pair_q      <= pair_d;
            cls_a_q     <= cls_a_d;
            cls_b_q     <= cls_b_d;
            onehot_q    <= onehot_d;
            cidx_q      <= cidx_d;
            out_valid_q <= out_valid_d;
            votes_q     <= votes_d;
        end
    end

    assign bus.in_ready_o     = (state_q == StIdle);
    assign bus.cfg_ready_o    = (state_q == StIdle);
    assign bus.out_valid_o    = out_valid_q;
    assign bus.class_onehot_o = onehot_q;
    assign bus.class_idx_o    = cidx_q;
endmodule
